// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Pipeline control unit for the three-stage RV32 core (IF / ID / EX).
// Arbitrates EX jump requests, EX multi-cycle busy, ID load-use hazards and the
// debug halt request. It drives hold/flush controls to pc_reg, if_id and id_ex,
// runs a RUN -> DRAIN -> HALTED state machine, a sticky busy watchdog and a
// stall performance counter.
//
// Parameters
//   BUSY_TIMEOUT   consecutive ex_busy_i cycles before busy_timeout_o sets
//                  (1 .. 65535)
//
// Ports
//   clk             in   core clock, rising edge
//   rst             in   synchronous active-high reset
//   jump_en_i       in   EX requests a PC redirect this cycle
//   jump_addr_i     in   redirect target [31:0]
//   ex_busy_i       in   EX is executing a multi-cycle op
//   load_use_i      in   ID instruction depends on the load in EX
//   halt_req_i      in   debug halt request, level-sensitive
//   jump_en_o       out  pc_reg loads jump_addr_o (overrides hold_pc_o)
//   jump_addr_o     out  redirect target, 0 when jump_en_o is low
//   hold_pc_o       out  pc_reg keeps its value
//   hold_if_id_o    out  if_id keeps its contents
//   hold_id_ex_o    out  id_ex keeps its contents
//   flush_if_id_o   out  if_id loads a NOP (wins over hold)
//   flush_id_ex_o   out  id_ex loads a NOP with reg_wen=0 (wins over hold)
//   halted_o        out  halted and drained (registered)
//   busy_timeout_o  out  sticky watchdog flag (registered)
//   stall_cnt_o     out  stall cycles counted in RUN (registered)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_busy_i,
  input  logic        load_use_i,
  input  logic        halt_req_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        halted_o,
  output logic        busy_timeout_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [15:0] BUSY_LIMIT = 16'(BUSY_TIMEOUT);

  state_e      state_q;
  state_e      state_d;
  logic        halted_q;
  logic        halted_d;
  logic [15:0] busy_cnt_q;
  logic [15:0] busy_cnt_d;
  logic        busy_timeout_q;
  logic        busy_timeout_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // State register of the halt/drain machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic of the halt/drain machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req_i && jump_en_i) begin
          // The jump already flushes both stages, so nothing is left to drain.
          state_d = ST_HALTED;
        end else if (halt_req_i) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // halt_req_i is not looked at here: a started drain always completes.
        if (jump_en_i) begin
          state_d = ST_HALTED;
        end else if (ex_busy_i) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (halt_req_i) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Hold/flush/jump controls, combinational from state and inputs.
  always_comb begin
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'h0000_0000;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    if (rst) begin
      jump_en_o = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (ex_busy_i) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
          end else if (load_use_i) begin
            // Freeze the front end and insert one bubble into EX.
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
          end else begin
            jump_en_o = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (ex_busy_i) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
          end else begin
            // id_ex retires through EX; if_id is kept for the resume.
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
          end
        end
        ST_HALTED: begin
          hold_pc_o     = 1'b1;
          hold_if_id_o  = 1'b1;
          flush_id_ex_o = 1'b1;
        end
        default: begin
          jump_en_o = 1'b0;
        end
      endcase
    end
  end

  // Next values of the watchdog, stall counter and halted flag.
  always_comb begin
    busy_cnt_d     = 16'd0;
    busy_timeout_d = busy_timeout_q;
    stall_cnt_d    = stall_cnt_q;
    halted_d       = (state_d == ST_HALTED);
    if (ex_busy_i) begin
      if (busy_cnt_q == BUSY_LIMIT) begin
        busy_cnt_d = busy_cnt_q;
      end else begin
        busy_cnt_d = busy_cnt_q + 16'd1;
      end
    end else begin
      busy_cnt_d = 16'd0;
    end
    // BUSY_LIMIT is at least 1, so a cleared counter never matches it.
    if (busy_cnt_d == BUSY_LIMIT) begin
      busy_timeout_d = 1'b1;
    end else begin
      busy_timeout_d = busy_timeout_q;
    end
    // Only stalls seen while running count; drain/halt holds do not.
    if ((state_q == ST_RUN) && hold_pc_o) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Watchdog, stall counter and halted flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q       <= 1'b0;
      busy_cnt_q     <= 16'd0;
      busy_timeout_q <= 1'b0;
      stall_cnt_q    <= 32'd0;
    end else begin
      halted_q       <= halted_d;
      busy_cnt_q     <= busy_cnt_d;
      busy_timeout_q <= busy_timeout_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign halted_o       = halted_q;
  assign busy_timeout_o = busy_timeout_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        ex_busy_i = 1'b0;
  logic        load_use_i = 1'b0;
  logic        halt_req_i = 1'b0;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        halted_o;
  logic        busy_timeout_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  // ctrl packs {jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex}
  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] addr;
    logic        halted;
    logic        bto;
    logic [31:0] stall;
  } exp_t;

  exp_t sb[$];

  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b011001;
  localparam logic [5:0] C_JMP  = 6'b100011;
  localparam logic [5:0] C_BUSY = 6'b011100;
  localparam logic [5:0] C_HOLD = 6'b011001;

  pipe_ctrl #(.BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_busy_i(ex_busy_i), .load_use_i(load_use_i), .halt_req_i(halt_req_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .halted_o(halted_o), .busy_timeout_o(busy_timeout_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int step, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL step %0d %s: observed %h expected %h", step, tag, obs, exp);
    end
  endtask

  // Drive one cycle, push the expectation, sample mid-cycle, pop and compare.
  task automatic cyc(input int step, input logic r, input logic jmp,
                     input logic [31:0] addr, input logic busy, input logic lu,
                     input logic halt, input logic [5:0] e_ctrl,
                     input logic [31:0] e_addr, input logic e_halted,
                     input logic e_bto, input logic [31:0] e_stall);
    exp_t e;
    exp_t got;
    rst = r; jump_en_i = jmp; jump_addr_i = addr;
    ex_busy_i = busy; load_use_i = lu; halt_req_i = halt;
    e.ctrl = e_ctrl; e.addr = e_addr; e.halted = e_halted;
    e.bto = e_bto; e.stall = e_stall;
    sb.push_back(e);
    #3;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", step, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("ctrl", step,
          {26'd0, jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           flush_if_id_o, flush_id_ex_o}, {26'd0, got.ctrl});
      chk("jump_addr", step, jump_addr_o, got.addr);
      chk("halted", step, {31'd0, halted_o}, {31'd0, got.halted});
      chk("busy_timeout", step, {31'd0, busy_timeout_o}, {31'd0, got.bto});
      chk("stall_cnt", step, stall_cnt_o, got.stall);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // step  rst jmp addr          busy lu halt  ctrl    addr    hlt bto stall
    cyc( 1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b0, 32'd0);
    cyc( 2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b0, 32'd0);
    // load-use bubble for exactly one cycle
    cyc( 3, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, C_LU,   32'h0,   1'b0, 1'b0, 32'd0);
    cyc( 4, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b0, 32'd1);
    // jump wins over busy; first watchdog burst is 3 cycles
    cyc( 5, 1'b0, 1'b1, 32'h100,      1'b1, 1'b0, 1'b0, C_JMP,  32'h100, 1'b0, 1'b0, 32'd1);
    cyc( 6, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, C_BUSY, 32'h0,   1'b0, 1'b0, 32'd1);
    cyc( 7, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, C_BUSY, 32'h0,   1'b0, 1'b0, 32'd2);
    cyc( 8, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b0, 32'd3);
    // second burst of 4 cycles trips the watchdog after its 4th edge
    cyc( 9, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, C_BUSY, 32'h0,   1'b0, 1'b0, 32'd3);
    cyc(10, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, C_BUSY, 32'h0,   1'b0, 1'b0, 32'd4);
    cyc(11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, C_BUSY, 32'h0,   1'b0, 1'b0, 32'd5);
    cyc(12, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, C_BUSY, 32'h0,   1'b0, 1'b0, 32'd6);
    cyc(13, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b1, 32'd7);
    // jump_addr_o stays 0 without a jump
    cyc(14, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b1, 32'd7);
    // halt with one busy cycle in DRAIN: halted after the 3rd edge
    cyc(15, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, C_IDLE, 32'h0,   1'b0, 1'b1, 32'd7);
    cyc(16, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, C_BUSY, 32'h0,   1'b0, 1'b1, 32'd7);
    cyc(17, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, C_HOLD, 32'h0,   1'b0, 1'b1, 32'd7);
    // HALTED ignores jump, busy and load-use
    cyc(18, 1'b0, 1'b1, 32'h300,      1'b1, 1'b1, 1'b1, C_HOLD, 32'h0,   1'b1, 1'b1, 32'd7);
    cyc(19, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_HOLD, 32'h0,   1'b1, 1'b1, 32'd7);
    cyc(20, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b1, 32'd7);
    // jump during DRAIN goes straight to HALTED
    cyc(21, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, C_IDLE, 32'h0,   1'b0, 1'b1, 32'd7);
    cyc(22, 1'b0, 1'b1, 32'h200,      1'b0, 1'b0, 1'b1, C_JMP,  32'h200, 1'b0, 1'b1, 32'd7);
    cyc(23, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_HOLD, 32'h0,   1'b1, 1'b1, 32'd7);
    // halt together with jump in RUN skips DRAIN
    cyc(24, 1'b0, 1'b1, 32'h40,       1'b0, 1'b0, 1'b1, C_JMP,  32'h40,  1'b0, 1'b1, 32'd7);
    cyc(25, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, C_HOLD, 32'h0,   1'b1, 1'b1, 32'd7);
    // reset while HALTED: controls forced low, registers cleared after the edge
    cyc(26, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, C_IDLE, 32'h0,   1'b1, 1'b1, 32'd7);
    cyc(27, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b0, 32'd0);
    cyc(28, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, C_LU,   32'h0,   1'b0, 1'b0, 32'd0);
    cyc(29, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b0, 32'd1);
    // halt_req dropped during DRAIN: the drain still completes
    cyc(30, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, C_IDLE, 32'h0,   1'b0, 1'b0, 32'd1);
    cyc(31, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_HOLD, 32'h0,   1'b0, 1'b0, 32'd1);
    cyc(32, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_HOLD, 32'h0,   1'b1, 1'b0, 32'd1);
    cyc(33, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, C_IDLE, 32'h0,   1'b0, 1'b0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
